// File: rtl/cpu86_io_pkg.sv
// Shared definitions for the cpu86 I/O responder: request field layout,
// response FSM states and the unmapped-port read value.
package cpu86_io_pkg;

  localparam int unsigned IO_REQ_DATA_LSB = 0;
  localparam int unsigned IO_REQ_DATA_MSB = 15;
  localparam int unsigned IO_REQ_PORT_LSB = 16;
  localparam int unsigned IO_REQ_PORT_MSB = 31;
  localparam int unsigned IO_REQ_WR_BIT   = 32;
  localparam int unsigned IO_REQ_WORD_BIT = 33;

  localparam logic [15:0] IO_UNMAPPED = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } io_resp_state_t;

endpackage

// File: rtl/cpu86_io_responder_if.sv
// Request/response/interrupt channels between cpu86 and the I/O responder.
interface cpu86_io_responder_if;

  logic        s_axis_io_req_tvalid;
  logic        s_axis_io_req_tready;
  logic [39:0] s_axis_io_req_tdata;
  logic        m_axis_io_res_tvalid;
  logic        m_axis_io_res_tready;
  logic [15:0] m_axis_io_res_tdata;
  logic        interrupt_valid;
  logic [7:0]  interrupt_data;
  logic        interrupt_ack;

  modport master (
    output s_axis_io_req_tvalid, s_axis_io_req_tdata, m_axis_io_res_tready, interrupt_ack,
    input  s_axis_io_req_tready, m_axis_io_res_tvalid, m_axis_io_res_tdata,
           interrupt_valid, interrupt_data
  );

  modport slave (
    input  s_axis_io_req_tvalid, s_axis_io_req_tdata, m_axis_io_res_tready, interrupt_ack,
    output s_axis_io_req_tready, m_axis_io_res_tvalid, m_axis_io_res_tdata,
           interrupt_valid, interrupt_data
  );

endinterface

// File: rtl/cpu86_io_timer.sv
// One-shot down-counter that raises a sticky interrupt on its 1->0 step.
// Present only when CPU86_IO_IRQ_EN is defined; otherwise outputs are idle.
module cpu86_io_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [15:0] i_load_val,
  input  logic        i_ack,
  output logic [15:0] o_count,
  output logic        o_irq_valid
);

`ifdef CPU86_IO_IRQ_EN
  logic [15:0] r_count;
  logic        r_irq;

  // Count down to zero; expiry sets the interrupt, ack clears it unless a new expiry lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_irq   <= 1'b0;
    end else begin
      if (i_load)
        r_count <= i_load_val;
      else if (r_count != 16'd0)
        r_count <= r_count - 16'd1;

      if (!i_load && (r_count == 16'd1))
        r_irq <= 1'b1;
      else if (r_irq && i_ack)
        r_irq <= 1'b0;
    end
  end

  assign o_count     = r_count;
  assign o_irq_valid = r_irq;
`else
  logic w_unused;
  assign w_unused    = ^{clk, rst, i_load, i_load_val, i_ack};
  assign o_count     = '0;
  assign o_irq_valid = 1'b0;
`endif

endmodule

// File: rtl/cpu86_io_responder.sv
// Bench-side I/O peripheral for cpu86: a window of 16-bit registers served
// over IN/OUT with fixed read latency, plus a one-shot interrupt timer.
// Optional feature macro: CPU86_IO_IRQ_EN (timer port and interrupt).
module cpu86_io_responder
  import cpu86_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'h0040,
  parameter int unsigned NUM_REGS   = 8,
  parameter logic [15:0] TIMER_PORT = 16'h0080,
  parameter logic [7:0]  IRQ_VECTOR = 8'h08,
  parameter int unsigned RD_LATENCY = 2
) (
  input logic                 clk,
  input logic                 reset,
  cpu86_io_responder_if.slave io
);

  localparam int unsigned IDXW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [16:0] WIN_END  = {1'b0, BASE_ADDR} + 17'(2 * NUM_REGS);
  localparam logic [7:0]  LAT_LOAD = (RD_LATENCY > 0) ? 8'(RD_LATENCY - 1) : 8'd0;

  io_resp_state_t r_state;
  logic           r_req_ready;
  logic           r_res_valid;
  logic [15:0]    r_res_data;
  logic [7:0]     r_cnt;
  logic [15:0]    r_regs [NUM_REGS];

  logic            w_req_fire;
  logic [15:0]     w_port;
  logic [15:0]     w_wdata;
  logic            w_wr;
  logic            w_word;
  logic [15:0]     w_off;
  logic [IDXW-1:0] w_idx;
  logic            w_reg_hit;
  logic            w_tmr_hit;
  logic [15:0]     w_rdata;
  logic [15:0]     w_tmr_count;
  logic            w_tmr_irq;
  logic            w_unused;

  assign w_req_fire = io.s_axis_io_req_tvalid & r_req_ready;
  assign w_port     = io.s_axis_io_req_tdata[IO_REQ_PORT_MSB:IO_REQ_PORT_LSB];
  assign w_wdata    = io.s_axis_io_req_tdata[IO_REQ_DATA_MSB:IO_REQ_DATA_LSB];
  assign w_wr       = io.s_axis_io_req_tdata[IO_REQ_WR_BIT];
  assign w_word     = io.s_axis_io_req_tdata[IO_REQ_WORD_BIT];
  assign w_off      = w_port - BASE_ADDR;
  assign w_idx      = w_off[IDXW:1];
  assign w_reg_hit  = (w_port >= BASE_ADDR) && ({1'b0, w_port} < WIN_END);
  assign w_unused   = ^{io.s_axis_io_req_tdata[39:34], w_off[15:IDXW+1], w_off[0]};

`ifdef CPU86_IO_IRQ_EN
  assign w_tmr_hit = (w_port == TIMER_PORT);
`else
  assign w_tmr_hit = 1'b0;
`endif

  // Read data mux: timer port first, then register window, else unmapped
  always_comb begin
    w_rdata = IO_UNMAPPED;
    if (w_tmr_hit)
      w_rdata = w_word ? w_tmr_count : {8'h00, w_tmr_count[7:0]};
    else if (w_reg_hit) begin
      if (w_word)
        w_rdata = r_regs[w_idx];
      else if (w_port[0])
        w_rdata = {8'h00, r_regs[w_idx][15:8]};
      else
        w_rdata = {8'h00, r_regs[w_idx][7:0]};
    end
  end

  // Register bank writes happen on the request handshake cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
    end else if (w_req_fire && w_wr && w_reg_hit && !w_tmr_hit) begin
      if (w_word)
        r_regs[w_idx] <= w_wdata;
      else if (w_port[0])
        r_regs[w_idx][15:8] <= w_wdata[7:0];
      else
        r_regs[w_idx][7:0] <= w_wdata[7:0];
    end
  end

  // Response FSM: read data is captured at accept, then held through WAIT/RESP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req_fire && !w_wr) begin
            r_res_data  <= w_rdata;
            r_req_ready <= 1'b0;
            if (RD_LATENCY > 0) begin
              r_state <= WAIT;
              r_cnt   <= LAT_LOAD;
            end else begin
              r_state     <= RESP;
              r_res_valid <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 8'd0) begin
            r_state     <= RESP;
            r_res_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        RESP: begin
          if (io.m_axis_io_res_tready) begin
            r_state     <= IDLE;
            r_res_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_res_valid <= 1'b0;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  cpu86_io_timer u_timer (
    .clk         (clk),
    .rst         (reset),
    .i_load      (w_req_fire & w_wr & w_tmr_hit),
    .i_load_val  (w_word ? w_wdata : {8'h00, w_wdata[7:0]}),
    .i_ack       (io.interrupt_ack),
    .o_count     (w_tmr_count),
    .o_irq_valid (w_tmr_irq)
  );

  assign io.s_axis_io_req_tready = r_req_ready;
  assign io.m_axis_io_res_tvalid = r_res_valid;
  assign io.m_axis_io_res_tdata  = r_res_data;
  assign io.interrupt_valid      = w_tmr_irq;
  assign io.interrupt_data       = IRQ_VECTOR;

endmodule
